// File: rtl/hams_merge_tree.sv
// hams_merge_tree: N-way streaming merge sorter built from 2:1 merge nodes; optional HAMS_MERGE_ORDER_CHK_EN adds per-lane order checking
package hams_pkg;
  localparam int INFO_W = 16;
  typedef struct packed {
    logic [INFO_W-1:0] info;
    logic [15:0]       data;
  } pair;
endpackage

module hams_merge_tree #(
  parameter int NUM_WAYS   = 4,
  parameter int NODE_DEPTH = 2,
  parameter int DESCEND    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WAYS-1:0]           lane_en,
  input  logic [NUM_WAYS-1:0]           in_vld,
  input  logic [NUM_WAYS-1:0]           in_last,
  input  hams_pkg::pair [NUM_WAYS-1:0]  in_data,
  output logic [NUM_WAYS-1:0]           in_rdy,
  output logic                          out_vld,
  output logic                          out_last,
  output hams_pkg::pair                 out_data,
  input  logic                          out_rdy,
  output logic                          busy,
  output logic [NUM_WAYS-1:0]           order_err
);
  localparam int N  = NUM_WAYS;
  localparam int AW = $clog2(NODE_DEPTH);
  localparam int PW = $bits(hams_pkg::pair);

  // Sources are heap-indexed: 1..N-1 are node FIFO heads (1 = root), N..2N-1 are lanes.
  logic [2*N-1:1] w_vld, w_last, w_pop;
  hams_pkg::pair  w_data [2*N-1:1];
  logic [2*N-1:2] r_sdone;
  logic [N-1:0]   r_en, w_en;
  logic           r_busy, w_start, w_end;

  assign w_en    = r_busy ? r_en : lane_en;
  assign w_start = |(in_vld & in_rdy);
  assign w_end   = out_vld & out_rdy & out_last;
  assign busy    = r_busy;

  // batch tracking: busy, enables frozen for the batch, per-source done once its last is taken
  always_ff @(posedge clk)
    if (rst) begin
      r_busy  <= 1'b0;
      r_en    <= '0;
      r_sdone <= '0;
    end else begin
      r_busy  <= !w_end && (r_busy || w_start);
      r_en    <= r_busy ? r_en : lane_en;
      r_sdone <= w_end ? '0 : r_sdone | (w_pop[2*N-1:2] & w_last[2*N-1:2]);
    end

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign w_vld[N+i]  = in_vld[i] & w_en[i] & ~r_sdone[N+i];
    assign w_last[N+i] = in_last[i];
    assign w_data[N+i] = in_data[i];
    assign in_rdy[i]   = w_pop[N+i] & ~rst;
  end

  for (genvar n = 1; n < N; n++) begin : g_node
    localparam int C = N >> $clog2(n + 1);
    logic [PW:0]   r_mem [NODE_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          w_dl, w_dr, w_le, w_tl, w_tr, w_push;
    logic [PW:0]   w_in;
    assign w_dl   = r_sdone[2*n] | ~|w_en[2*n*C-N +: C];
    assign w_dr   = r_sdone[2*n+1] | ~|w_en[(2*n+1)*C-N +: C];
    assign w_le   = (DESCEND != 0) ? (w_data[2*n].info >= w_data[2*n+1].info)
                                   : (w_data[2*n].info <= w_data[2*n+1].info);
    assign w_tl   = w_vld[2*n] & (w_vld[2*n+1] ? w_le : w_dr);
    assign w_tr   = w_vld[2*n+1] & (w_vld[2*n] ? !w_le : w_dl);
    assign w_push = (r_cnt != (AW+1)'(NODE_DEPTH)) & (w_tl | w_tr);
    assign w_pop[2*n]   = w_push & w_tl;
    assign w_pop[2*n+1] = w_push & w_tr;
    assign w_in   = w_tl ? {w_last[2*n] & w_dr, w_data[2*n]} : {w_last[2*n+1] & w_dl, w_data[2*n+1]};
    assign w_vld[n] = r_cnt != '0;
    assign {w_last[n], w_data[n]} = r_mem[r_rp];
    // node FIFO storage
    always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= w_in;
    // node FIFO pointers and occupancy
    always_ff @(posedge clk)
      if (rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        r_wp  <= r_wp + AW'(w_push);
        r_rp  <= r_rp + AW'(w_pop[n]);
        r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop[n]);
      end
  end

  assign w_pop[1] = w_vld[1] & out_rdy;
  assign out_vld  = w_vld[1];
  assign out_last = w_vld[1] & w_last[1];
  assign out_data = w_vld[1] ? w_data[1] : '0;

`ifdef HAMS_MERGE_ORDER_CHK_EN
  logic [hams_pkg::INFO_W-1:0] r_prev [N];
  logic [N-1:0]                r_seen, r_err;
  // per-lane order checker; first element of a batch only seeds the reference
  always_ff @(posedge clk)
    if (rst) begin
      r_seen <= '0;
      r_err  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_vld[i] && in_rdy[i]) begin
          r_prev[i] <= in_data[i].info;
          r_seen[i] <= 1'b1;
          if (r_seen[i] && ((DESCEND != 0) ? (in_data[i].info > r_prev[i]) : (in_data[i].info < r_prev[i])))
            r_err[i] <= 1'b1;
        end
        if (w_end) r_seen[i] <= 1'b0;
      end
    end
  assign order_err = r_err;
`else
  assign order_err = '0;
`endif
endmodule

// File: doc/hams_merge_tree.md
Name: hams_merge_tree

Overview:
Parametrised N-way streaming merge sorter for the HAMS datapath. It takes NUM_WAYS independently sorted streams of hams_pkg::pair, keyed on .info, and emits one globally sorted stream. It is built as a binary tree of 2:1 merge nodes, each with a small output FIFO. It supersedes the fixed 4:1 merge stage, adding per-lane end-of-stream, correct drain when lanes finish unevenly, valid/ready backpressure, back-to-back batches and an ascending/descending mode.

Parameters:
NUM_WAYS, 4, number of input lanes; power of 2, range 2..16; LEVELS = log2(NUM_WAYS).
NODE_DEPTH, 2, entries in each node output FIFO; power of 2, at least 2.
DESCEND, 0, 0 = ascending .info order, 1 = descending.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
lane_en  in  NUM_WAYS  lane participates in the batch; sampled only while busy=0.
in_vld  in  NUM_WAYS  per-lane element valid.
in_last  in  NUM_WAYS  per-lane final element of the batch.
in_data  in  NUM_WAYS x $bits(pair)  per-lane element.
in_rdy  out  NUM_WAYS  per-lane ready.
out_vld  out  1  merged element valid.
out_last  out  1  final element of the merged batch.
out_data  out  $bits(pair)  merged element.
out_rdy  in  1  downstream ready.
busy  out  1  batch in progress.
order_err  out  NUM_WAYS  sticky per-lane input ordering error; only active with the optional feature.

Behaviour:
- Handshake: a transfer occurs when vld and rdy are both high on a clk edge. vld and data must stay stable until the transfer; vld must not depend on rdy.
- Leaf lanes: in_rdy[i] = leaf node accepts and lane i not done and rst=0. After a lane's in_last transfer, the lane is done; in_rdy[i]=0 until the batch ends.
- Node state: per side, head (FIFO non-empty or leaf vld) and done flag.
- Node pick rule, evaluated each cycle when the node FIFO is not full:
  - Both heads present: take the smaller .info (larger if DESCEND). On a tie, take the left side (lower lane index).
  - One side done: take the other side's head.
  - A side neither done nor with a head: stall. The node never guesses.
- Emitted last = (taken element's last) AND (other side done). A node sets its own done when it emits last.
- Root: the root FIFO head drives out_*; out_vld is registered. Sustained throughput is 1 element/cycle when unstalled.
- Latency: with all lanes presenting at cycle t into an empty tree, the first out_vld is at t+LEVELS.
- Disabled lanes: treated as done from batch start and never drive the tree.
- Batch boundaries:
  - Batch start: busy rises on the first input transfer.
  - Batch end: the out_last transfer clears all done flags and busy in the same edge.
  - The next batch's inputs are accepted from the following cycle, with no bubble beyond that.
- All lanes disabled: no batch starts, busy stays 0, in_rdy=0.
- Every enabled lane must deliver at least one element; an empty lane is unsupported.
- FIFO full: the node stalls its pick and backpressures toward the leaves. No data is dropped or duplicated.
- Reset values (rst high):
  - All FIFOs flushed and done flags cleared.
  - out_vld=0, out_last=0, out_data=0, busy=0, in_rdy=0, order_err=0, all from the next edge.
  - Reset mid-batch discards all in-flight data; the next batch starts clean.

Optional Feature:
Macro HAMS_MERGE_ORDER_CHK_EN.
- Defined: per lane, the last accepted .info is stored. Accepting an element that violates the order (strictly smaller in ascending mode, strictly larger in descending) sets order_err[i]. The flag is sticky until rst. The first element of each batch is not compared. Merging continues unchanged.
- Undefined: order_err is tied to 0 and the checker registers are absent.

Test Plan:
1. NUM_WAYS=4, ascending. Lanes {1,5,9}, {2,6}, {3,7,11,12}, {4}, all presented at once, out_rdy=1 -> out 1,2,3,4,5,6,7,9,11,12; out_last only on 12; first out_vld at cycle t+2.
2. Ties: lane0 {3,3}, lane1 {3}, lane2 {2}, lane3 {3}. Tag .data with the lane id -> order 2(L2), 3(L0), 3(L0), 3(L1), 3(L3).
3. lane_en=4'b0101. Lanes 0 {10,20}, 2 {15}; lanes 1 and 3 driving garbage -> out 10,15,20; in_rdy[1], in_rdy[3] stay 0.
4. Uneven lengths with 50% random out_rdy: lane0 has 64 elements, lanes 1-3 have 1 each -> all 67 out, sorted, no loss. A second batch back-to-back is accepted the cycle after out_last.
5. rst asserted for 1 cycle after 3 outputs of a 10-element batch -> out_vld=0 and busy=0 next cycle; a fresh batch {8},{1},{4},{2} yields 1,2,4,8.
6. With HAMS_MERGE_ORDER_CHK_EN: lane1 sends {5,3,9} -> order_err=4'b0010 after the 3 is accepted, held until rst. Without the macro, order_err stays 0.
